iopmp_check_arbiter: RTL and testbench
======================================

# iopmp_check_arbiter

Shares the IOPMP entry table between NR_MASTERS transaction requesters and sequences the permission check. A round-robin arbiter accepts one request at a time. A state machine then walks the entry table one entry per cycle, evaluating OFF/TOR/NA4/NAPOT matches against the requester's memory domains. It returns allow/deny and emits an error-record capture pulse toward the IOPMP configuration register block.

## Interface
- NR_MASTERS, 2, number of requesters; SID width SW = max(1, $clog2(NR_MASTERS))
- NR_MD, 2, memory domains; MD m owns entries m*NR_ENTRIES .. (m+1)*NR_ENTRIES-1
- NR_ENTRIES, 8, entries per MD; E = NR_MD*NR_ENTRIES, index width EW = max(1, $clog2(E))
- PLEN, 34, physical address width
- IOPMP_LEN, 32, entry address width (= PLEN-2, word address)
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  NR_MASTERS  per-master request valid
- req_ready_o  out  NR_MASTERS  one-hot accept strobe
- req_addr_i  in  NR_MASTERS x PLEN  first byte address
- req_len_i  in  NR_MASTERS x 8  access length in bytes minus 1
- req_write_i  in  NR_MASTERS  1 = write, 0 = read
- srcmd_md_i  in  NR_MASTERS x NR_MD  per-master MD enable bitmap
- iopmp_en_i  in  1  IOPMP enable (ctl bit 0)
- entry_idx_o  out  EW  entry index under evaluation
- entry_addr_i  in  IOPMP_LEN  address of entry entry_idx_o (combinational)
- entry_prev_addr_i  in  IOPMP_LEN  address of entry entry_idx_o-1; 0 when index 0
- entry_cfg_i  in  8  cfg of entry entry_idx_o: bit0 R, bit1 W, [4:3] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bit7 L (ignored here)
- rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake
- rsp_sid_o  out  SW  granted master
- rsp_allow_o  out  1  1 = permitted
- err_valid_o  out  1  one-cycle record-capture pulse
- err_sid_o, err_addr_o, err_write_o, err_type_o  out  SW, PLEN, 1, 2  record fields; type 1 no-match, 2 partial/overflow, 3 permission
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, WALK, RESP. Reset: IDLE, all outputs 0, rr pointer 0, entry_idx_o 0.
- IDLE: the rr pointer p selects the first valid master at p, p+1, ... (mod NR_MASTERS). The winner gets req_ready_o for one cycle. The block latches sid, addr, last = addr + len, write, srcmd, and samples iopmp_en_i. p becomes winner+1.
  - iopmp_en_i = 0: RESP with allow=1.
  - addr + len carries out of PLEN: RESP, deny type 2.
  - Otherwise: WALK with idx = 0.
- WALK: evaluates entry idx using live table inputs. The entry is considered only when srcmd[idx / NR_ENTRIES] = 1 and A != 0. Word addresses are a = addr[PLEN-1:2] and b = last[PLEN-1:2].
  - TOR hit(x): prev <= x < entry_addr.
  - NA4 hit(x): x == entry_addr.
  - NAPOT hit(x): M = entry_addr ^ (entry_addr + 1); ((x ^ entry_addr) & ~M) == 0.
  - hit(a) and hit(b): allow iff (write ? W : R); else deny type 3; go to RESP.
  - Exactly one of hit(a), hit(b): deny type 2; go to RESP.
  - Neither: idx + 1. At idx = E-1 with no match: deny type 1; go to RESP.
  - Lowest matching index wins. Non-considered entries still consume one cycle.
- RESP: rsp_valid_o and its fields are held stable until rsp_ready_i, then IDLE. On deny, err_valid_o is high only in the first RESP cycle, with err_addr_o = first byte address.
- No request is accepted while busy. req_ready_o never asserts outside IDLE.

## Timing
- Accept in cycle T:
  - Bypass or overflow: rsp_valid_o from T+1.
  - Decision at entry k: rsp_valid_o from T+2+k.
  - No match: from T+1+E.
- Earliest next accept is the cycle after the rsp handshake.
- err_valid_o fires exactly once per denied request, independent of rsp backpressure.
- Simultaneous requests are resolved by rr only. A losing request stays pending; the requester must hold it.
- Reset mid-WALK/RESP: immediate return to IDLE. No response or err pulse is produced for the aborted request.

## Test plan
- Reset, drive req_valid_i = 2'b11 -> all outputs 0 during reset. First accept after release goes to master 0, then master 1.
- iopmp_en_i = 0, master 0 read 0x1000 len 3 -> rsp allow=1 sid=0 at T+1, err_valid_o stays 0.
- Entry 2 NAPOT addr 0x21FF (region 0x8000-0x8FFF), cfg R=1 W=0 A=3, master 0 srcmd 2'b01:
  - read 0x8010 len 7 -> allow=1 at T+4.
  - write 0x8010 len 7 -> allow=0, err type 3, err_addr 0x8010.
- Same table, read 0x8FFC len 7 -> deny type 2 at T+4.
- Same table, read 0x3_FFFF_FFFC len 7 -> deny type 2 at T+1 (overflow).
- Master 1 srcmd 2'b10, read 0x8010 -> no match, deny type 1 at T+17, err_sid 1.
- Same request with rsp_ready_i = 0 for 5 cycles -> rsp fields stable, err_valid_o exactly one pulse, req_ready_o stays 0.
- Assert rst_ni low mid-WALK -> IDLE next cycle, no rsp.

Source files
------------

// File: rtl/iopmp_check_arbiter.sv
// IOPMP check arbiter: round-robin intake of master requests, then a serial walk
// of the shared entry table producing allow/deny plus an error-record capture pulse.
module iopmp_check_arbiter #(
  parameter  int NR_MASTERS = 2,
  parameter  int NR_MD      = 2,
  parameter  int NR_ENTRIES = 8,
  parameter  int PLEN       = 34,
  parameter  int IOPMP_LEN  = 32,
  localparam int SW         = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1,
  localparam int E          = NR_MD * NR_ENTRIES,
  localparam int EW         = (E > 1) ? $clog2(E) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NR_MASTERS-1:0]               req_valid_i,
  output logic [NR_MASTERS-1:0]               req_ready_o,
  input  logic [NR_MASTERS-1:0][PLEN-1:0]     req_addr_i,
  input  logic [NR_MASTERS-1:0][7:0]          req_len_i,
  input  logic [NR_MASTERS-1:0]               req_write_i,
  input  logic [NR_MASTERS-1:0][NR_MD-1:0]    srcmd_md_i,
  input  logic                                iopmp_en_i,
  output logic [EW-1:0]                       entry_idx_o,
  input  logic [IOPMP_LEN-1:0]                entry_addr_i,
  input  logic [IOPMP_LEN-1:0]                entry_prev_addr_i,
  input  logic [7:0]                          entry_cfg_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [SW-1:0]                       rsp_sid_o,
  output logic                                rsp_allow_o,
  output logic                                err_valid_o,
  output logic [SW-1:0]                       err_sid_o,
  output logic [PLEN-1:0]                     err_addr_o,
  output logic                                err_write_o,
  output logic [1:0]                          err_type_o,
  output logic                                busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_ptr;
  logic [SW-1:0]       r_sid;
  logic [PLEN-1:0]     r_addr;
  logic [PLEN-1:0]     r_last;
  logic                r_write;
  logic [NR_MD-1:0]    r_srcmd;
  logic [EW-1:0]       r_idx;
  logic                r_rsp_valid;
  logic                r_allow;
  logic                r_err_valid;
  logic [SW-1:0]       r_err_sid;
  logic [PLEN-1:0]     r_err_addr;
  logic                r_err_write;
  logic [1:0]          r_err_type;

  logic                w_found;
  logic [SW-1:0]       w_win;
  logic [SW:0]         w_cand;
  logic [SW-1:0]       w_next_ptr;
  logic [PLEN:0]       w_sum;
  logic                w_consider;
  logic                w_hit_a;
  logic                w_hit_b;
  logic                w_perm;
  logic [1:0]          w_mode;
  logic                w_unused_bits;

  function automatic logic entry_hit(input logic [1:0]           mode,
                                     input logic [IOPMP_LEN-1:0] x,
                                     input logic [IOPMP_LEN-1:0] ea,
                                     input logic [IOPMP_LEN-1:0] prev);
    logic [IOPMP_LEN-1:0] m;
    m = ea ^ (ea + IOPMP_LEN'(1));
    case (mode)
      2'd1:    entry_hit = (prev <= x) && (x < ea);
      2'd2:    entry_hit = (x == ea);
      2'd3:    entry_hit = ((x ^ ea) & ~m) == '0;
      default: entry_hit = 1'b0;
    endcase
  endfunction

  // Round-robin search starting at the pointer, wrapping modulo NR_MASTERS.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NR_MASTERS; k++) begin
      w_cand = {1'b0, r_ptr} + (SW+1)'(k);
      if (w_cand >= (SW+1)'(NR_MASTERS)) w_cand = w_cand - (SW+1)'(NR_MASTERS);
      if (!w_found && req_valid_i[w_cand[SW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[SW-1:0];
      end
    end
    w_next_ptr = (w_win == SW'(NR_MASTERS-1)) ? '0 : w_win + SW'(1);
  end

  always_comb begin
    req_ready_o = '0;
    if (r_state == S_IDLE && rst_ni && w_found) req_ready_o[w_win] = 1'b1;
  end

  assign w_sum = {1'b0, req_addr_i[w_win]} + (PLEN+1)'(req_len_i[w_win]);

  always_comb begin
    w_consider = 1'b0;
    for (int unsigned m = 0; m < NR_MD; m++) begin
      if (r_srcmd[m] && (32'(r_idx) >= m*NR_ENTRIES) && (32'(r_idx) < (m+1)*NR_ENTRIES))
        w_consider = 1'b1;
    end
    w_mode = entry_cfg_i[4:3];
    if (w_mode == 2'd0) w_consider = 1'b0;
    w_hit_a = entry_hit(w_mode, r_addr[PLEN-1:2], entry_addr_i, entry_prev_addr_i);
    w_hit_b = entry_hit(w_mode, r_last[PLEN-1:2], entry_addr_i, entry_prev_addr_i);
    w_perm  = r_write ? entry_cfg_i[1] : entry_cfg_i[0];
  end

  assign w_unused_bits = ^{entry_cfg_i[7:5], entry_cfg_i[2], r_last[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_sid       <= '0;
      r_addr      <= '0;
      r_last      <= '0;
      r_write     <= 1'b0;
      r_srcmd     <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_allow     <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_sid   <= '0;
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
      r_err_type  <= '0;
    end else begin
      r_err_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sid   <= w_win;
            r_addr  <= req_addr_i[w_win];
            r_last  <= w_sum[PLEN-1:0];
            r_write <= req_write_i[w_win];
            r_srcmd <= srcmd_md_i[w_win];
            r_ptr   <= w_next_ptr;
            r_idx   <= '0;
            if (!iopmp_en_i) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_allow     <= 1'b1;
            end else if (w_sum[PLEN]) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_allow     <= 1'b0;
              r_err_valid <= 1'b1;
              r_err_sid   <= w_win;
              r_err_addr  <= req_addr_i[w_win];
              r_err_write <= req_write_i[w_win];
              r_err_type  <= 2'd2;
            end else begin
              r_state <= S_WALK;
            end
          end
        end
        S_WALK: begin
          if (w_consider && (w_hit_a || w_hit_b)) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_idx       <= '0;
            r_allow     <= w_hit_a && w_hit_b && w_perm;
            if (!(w_hit_a && w_hit_b && w_perm)) begin
              r_err_valid <= 1'b1;
              r_err_sid   <= r_sid;
              r_err_addr  <= r_addr;
              r_err_write <= r_write;
              r_err_type  <= (w_hit_a && w_hit_b) ? 2'd3 : 2'd2;
            end
          end else if (r_idx == EW'(E-1)) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_idx       <= '0;
            r_allow     <= 1'b0;
            r_err_valid <= 1'b1;
            r_err_sid   <= r_sid;
            r_err_addr  <= r_addr;
            r_err_write <= r_write;
            r_err_type  <= 2'd1;
          end else begin
            r_idx <= r_idx + EW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign entry_idx_o = r_idx;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_sid_o   = r_sid;
  assign rsp_allow_o = r_allow;
  assign err_valid_o = r_err_valid;
  assign err_sid_o   = r_err_sid;
  assign err_addr_o  = r_err_addr;
  assign err_write_o = r_err_write;
  assign err_type_o  = r_err_type;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_iopmp_check_arbiter.sv
// Directed bench for iopmp_check_arbiter with a small behavioural entry table.
module tb_iopmp_check_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][33:0] req_addr_i;
  logic [1:0][7:0]  req_len_i;
  logic [1:0]       req_write_i;
  logic [1:0][1:0]  srcmd_md_i;
  logic             iopmp_en_i;
  logic [3:0]       entry_idx_o;
  logic [31:0]      entry_addr_i;
  logic [31:0]      entry_prev_addr_i;
  logic [7:0]       entry_cfg_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_sid_o;
  logic             rsp_allow_o;
  logic             err_valid_o;
  logic             err_sid_o;
  logic [33:0]      err_addr_o;
  logic             err_write_o;
  logic [1:0]       err_type_o;
  logic             busy_o;

  logic [31:0] tbl_addr [16];
  logic [7:0]  tbl_cfg  [16];

  int n_checks = 0;
  int n_errors = 0;

  iopmp_check_arbiter #(.NR_MASTERS(2), .NR_MD(2), .NR_ENTRIES(8), .PLEN(34), .IOPMP_LEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_write_i(req_write_i),
    .srcmd_md_i(srcmd_md_i), .iopmp_en_i(iopmp_en_i),
    .entry_idx_o(entry_idx_o), .entry_addr_i(entry_addr_i),
    .entry_prev_addr_i(entry_prev_addr_i), .entry_cfg_i(entry_cfg_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_sid_o(rsp_sid_o), .rsp_allow_o(rsp_allow_o),
    .err_valid_o(err_valid_o), .err_sid_o(err_sid_o), .err_addr_o(err_addr_o),
    .err_write_o(err_write_o), .err_type_o(err_type_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    entry_addr_i      = tbl_addr[entry_idx_o];
    entry_cfg_i       = tbl_cfg[entry_idx_o];
    entry_prev_addr_i = (entry_idx_o == 4'd0) ? 32'd0 : tbl_addr[entry_idx_o - 4'd1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Raise a request, wait (bounded) for its accept, drop valid; returns in cycle T+1.
  task automatic issue(input int m, input logic [33:0] addr, input logic [7:0] len, input logic wr);
    int n;
    req_addr_i[m]  = addr;
    req_len_i[m]   = len;
    req_write_i[m] = wr;
    req_valid_i[m] = 1'b1;
    #1;
    n = 0;
    while (!req_ready_o[m] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("accept_timeout", 64'(n), 64'd0);
    tick();
    req_valid_i[m] = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    if (!rsp_valid_o) check("rsp_timeout", 64'(lat), 64'd0);
  endtask

  int lat;
  int pulses;
  int quiet;
  logic       h_sid, h_allow;
  logic [1:0] h_type;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl_addr[i] = 32'd0;
      tbl_cfg[i]  = 8'd0;
    end
    tbl_addr[2]   = 32'h0000_21FF;
    tbl_cfg[2]    = 8'h19;
    rst_ni        = 1'b0;
    req_valid_i   = 2'b11;
    req_addr_i    = '0;
    req_len_i     = '0;
    req_write_i   = '0;
    srcmd_md_i[0] = 2'b01;
    srcmd_md_i[1] = 2'b10;
    iopmp_en_i    = 1'b0;
    rsp_ready_i   = 1'b1;

    tick();
    tick();
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_err_valid", 64'(err_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_idx", 64'(entry_idx_o), 64'd0);
    check("rst_allow", 64'(rsp_allow_o), 64'd0);

    rst_ni = 1'b1;
    #1;
    check("rr_first_ready", 64'(req_ready_o), 64'b01);
    tick();
    req_valid_i = 2'b10;
    check("rr_first_sid", 64'(rsp_sid_o), 64'd0);
    check("rr_first_valid", 64'(rsp_valid_o), 64'd1);
    check("rr_busy_ready", 64'(req_ready_o), 64'd0);
    tick();
    check("rr_second_ready", 64'(req_ready_o), 64'b10);
    tick();
    req_valid_i = 2'b00;
    check("rr_second_sid", 64'(rsp_sid_o), 64'd1);
    tick();

    issue(0, 34'h1000, 8'd3, 1'b0);
    wait_rsp(lat);
    check("bypass_lat", 64'(lat), 64'd1);
    check("bypass_allow", 64'(rsp_allow_o), 64'd1);
    check("bypass_sid", 64'(rsp_sid_o), 64'd0);
    check("bypass_err", 64'(err_valid_o), 64'd0);
    tick();

    iopmp_en_i = 1'b1;
    issue(0, 34'h8010, 8'd7, 1'b0);
    wait_rsp(lat);
    check("napot_rd_lat", 64'(lat), 64'd4);
    check("napot_rd_allow", 64'(rsp_allow_o), 64'd1);
    check("napot_rd_err", 64'(err_valid_o), 64'd0);
    tick();

    issue(0, 34'h8010, 8'd7, 1'b1);
    wait_rsp(lat);
    check("napot_wr_lat", 64'(lat), 64'd4);
    check("napot_wr_allow", 64'(rsp_allow_o), 64'd0);
    check("napot_wr_err", 64'(err_valid_o), 64'd1);
    check("napot_wr_type", 64'(err_type_o), 64'd3);
    check("napot_wr_addr", 64'(err_addr_o), 64'h8010);
    check("napot_wr_write", 64'(err_write_o), 64'd1);
    tick();
    check("napot_wr_err_drop", 64'(err_valid_o), 64'd0);

    issue(0, 34'h8FFC, 8'd7, 1'b0);
    wait_rsp(lat);
    check("partial_lat", 64'(lat), 64'd4);
    check("partial_allow", 64'(rsp_allow_o), 64'd0);
    check("partial_type", 64'(err_type_o), 64'd2);
    tick();

    issue(0, 34'h3_FFFF_FFFC, 8'd7, 1'b0);
    wait_rsp(lat);
    check("ovf_lat", 64'(lat), 64'd1);
    check("ovf_allow", 64'(rsp_allow_o), 64'd0);
    check("ovf_type", 64'(err_type_o), 64'd2);
    check("ovf_err", 64'(err_valid_o), 64'd1);
    check("ovf_addr", 64'(err_addr_o), 64'h3_FFFF_FFFC);
    tick();

    issue(1, 34'h8010, 8'd7, 1'b0);
    wait_rsp(lat);
    check("nomatch_lat", 64'(lat), 64'd17);
    check("nomatch_allow", 64'(rsp_allow_o), 64'd0);
    check("nomatch_type", 64'(err_type_o), 64'd1);
    check("nomatch_sid", 64'(err_sid_o), 64'd1);
    tick();

    rsp_ready_i = 1'b0;
    issue(1, 34'h8010, 8'd7, 1'b0);
    wait_rsp(lat);
    check("bp_lat", 64'(lat), 64'd17);
    pulses  = int'(err_valid_o);
    h_sid   = rsp_sid_o;
    h_allow = rsp_allow_o;
    h_type  = err_type_o;
    check("bp_sid", 64'(h_sid), 64'd1);
    req_valid_i[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      pulses += int'(err_valid_o);
      check("bp_valid_held", 64'(rsp_valid_o), 64'd1);
      check("bp_sid_held", 64'(rsp_sid_o), 64'(h_sid));
      check("bp_allow_held", 64'(rsp_allow_o), 64'(h_allow));
      check("bp_type_held", 64'(err_type_o), 64'(h_type));
      check("bp_no_ready", 64'(req_ready_o), 64'd0);
    end
    check("bp_err_pulses", 64'(pulses), 64'd1);
    req_valid_i[0] = 1'b0;
    rsp_ready_i    = 1'b1;
    tick();
    check("bp_idle", 64'(busy_o), 64'd0);
    check("bp_rsp_drop", 64'(rsp_valid_o), 64'd0);

    issue(0, 34'h8010, 8'd7, 1'b1);
    tick();
    check("abort_busy_before", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_rsp", 64'(rsp_valid_o), 64'd0);
    check("abort_idx", 64'(entry_idx_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      quiet += int'(rsp_valid_o) + int'(err_valid_o) + int'(busy_o);
    end
    check("abort_quiet", 64'(quiet), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
